axis_byte_packer: RTL and testbench

//  Sits directly downstream of the AXI read DMA in the e1000 datapath and consumes its 32-bit

---
 rtl/axis_byte_packer_if.sv | 31 +++
 rtl/axis_byte_packer.sv | 148 ++++++++++++++
 tb/tb_axis_byte_packer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_byte_packer_if.sv
// AXI4-Stream style bus bundle used by axis_byte_packer for its input and
// output streams.
//   tdata  : 32-bit payload, byte n on [8n+7:8n]
//   tkeep  : per-byte lane enables
//   tlast  : last beat of packet
//   tvalid : source has a beat
//   tready : sink accepts the beat
// The 'master' modport drives a stream; the 'slave' modport consumes one.
interface axis_byte_packer_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_byte_packer.sv
// axis_byte_packer
// Consumes the 32-bit read-DMA stream, whose first/last beats carry partial
// byte lanes, strips the null lanes and re-emits each packet densely packed
// from byte lane 0. All output beats carry tkeep=1111 except the final beat
// of a packet (0001/0011/0111/1111, or 0000 for an empty packet when
// DROP_EMPTY=0).
// Ports:
//   aclk       : clock, rising edge
//   aresetn    : asynchronous active-low reset
//   din        : input stream (slave modport)
//   dout       : packed output stream (master modport); lanes outside tkeep are 0
//   err_sparse : sticky flag, set when an accepted beat has non-contiguous tkeep
// Parameters:
//   DROP_EMPTY : 1 = packets with no valid bytes produce no output,
//                0 = such packets produce one beat with tkeep=0000, tlast=1
module axis_byte_packer #(
    parameter bit DROP_EMPTY = 1'b1
) (
    input  logic                aclk,
    input  logic                aresetn,
    axis_byte_packer_if.slave   din,
    axis_byte_packer_if.master  dout,
    output logic                err_sparse
);

    // Byte buffer holds up to 7 bytes; bytes at index >= cnt are always zero,
    // which is what keeps unused output lanes at 0.
    logic [55:0] byte_buf;
    logic [2:0]  cnt;
    logic        last_pend;
    logic        empty_pend;

    logic        in_fire;
    logic        out_fire;

    logic [1:0]  off;
    logic [2:0]  nb;
    logic [31:0] aligned;
    logic        sparse;

    logic [55:0] base_buf;
    logic [2:0]  base_cnt;
    logic [55:0] next_buf;
    logic [2:0]  next_cnt;

    function automatic logic [31:0] byte_mask(input logic [2:0] n);
        case (n)
            3'd0:    byte_mask = 32'h0000_0000;
            3'd1:    byte_mask = 32'h0000_00FF;
            3'd2:    byte_mask = 32'h0000_FFFF;
            3'd3:    byte_mask = 32'h00FF_FFFF;
            default: byte_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [3:0] keep_mask(input logic [2:0] n);
        case (n)
            3'd0:    keep_mask = 4'b0000;
            3'd1:    keep_mask = 4'b0001;
            3'd2:    keep_mask = 4'b0011;
            3'd3:    keep_mask = 4'b0111;
            default: keep_mask = 4'b1111;
        endcase
    endfunction

    // Input beat decode: lowest valid lane, valid byte count, lane-0 aligned data.
    always_comb begin
        off = 2'd0;
        if (din.tkeep[0])      off = 2'd0;
        else if (din.tkeep[1]) off = 2'd1;
        else if (din.tkeep[2]) off = 2'd2;
        else if (din.tkeep[3]) off = 2'd3;

        nb = {2'b00, din.tkeep[0]} + {2'b00, din.tkeep[1]}
           + {2'b00, din.tkeep[2]} + {2'b00, din.tkeep[3]};

        aligned = (din.tdata >> {off, 3'b000}) & byte_mask(nb);

        // Contiguous iff the keep bits above the offset form a solid run of nb ones.
        sparse = ((din.tkeep >> off) != keep_mask(nb));
    end

    // Outputs depend on registered state only.
    assign dout.tvalid = (cnt >= 3'd4) | (last_pend & (cnt != 3'd0)) | empty_pend;
    assign dout.tdata  = byte_buf[31:0];
    assign dout.tkeep  = (cnt >= 3'd4) ? 4'b1111 : keep_mask(cnt);
    assign dout.tlast  = (last_pend & (cnt <= 3'd4)) | empty_pend;

    // Combinational path from dout.tready lets a full buffer accept a new beat
    // in the same cycle it drains four bytes.
    assign din.tready = ~last_pend & ~empty_pend & ((cnt < 3'd4) | dout.tready);

    assign in_fire  = din.tvalid & din.tready;
    assign out_fire = dout.tvalid & dout.tready;

    // Drain first, then append at the post-drain fill level so a simultaneous
    // accept and emit neither loses nor duplicates bytes.
    always_comb begin
        base_buf = byte_buf;
        base_cnt = cnt;
        if (out_fire) begin
            base_buf = {32'd0, byte_buf[55:32]};
            base_cnt = (cnt >= 3'd4) ? (cnt - 3'd4) : 3'd0;
        end

        next_buf = base_buf;
        next_cnt = base_cnt;
        if (in_fire) begin
            next_buf = base_buf | ({24'd0, aligned} << {base_cnt, 3'b000});
            next_cnt = base_cnt + nb;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            byte_buf   <= '0;
            cnt        <= '0;
            last_pend  <= 1'b0;
            empty_pend <= 1'b0;
        end else if (out_fire && dout.tlast) begin
            // din.tready is low whenever tlast can be presented, so no
            // input beat needs merging here.
            byte_buf   <= '0;
            cnt        <= '0;
            last_pend  <= 1'b0;
            empty_pend <= 1'b0;
        end else begin
            byte_buf <= next_buf;
            cnt      <= next_cnt;
            if (in_fire && din.tlast) begin
                if (next_cnt != 3'd0) begin
                    last_pend <= 1'b1;
                end else if (!DROP_EMPTY) begin
                    empty_pend <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_sparse <= 1'b0;
        end else if (in_fire && sparse) begin
            err_sparse <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Self-checking bench for axis_byte_packer: directed cases from the packer's
// documented behaviour plus randomized packets checked against a byte-queue
// reference model. A second instance with DROP_EMPTY=0 covers empty packets.
module tb_axis_byte_packer;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axis_byte_packer_if din_if ();
    axis_byte_packer_if dout_if ();
    axis_byte_packer_if din2_if ();
    axis_byte_packer_if dout2_if ();

    logic err_sparse;
    logic err_sparse2;

    axis_byte_packer #(.DROP_EMPTY(1'b1)) u_dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .din        (din_if),
        .dout       (dout_if),
        .err_sparse (err_sparse)
    );

    axis_byte_packer #(.DROP_EMPTY(1'b0)) u_dut_keep (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .din        (din2_if),
        .dout       (dout2_if),
        .err_sparse (err_sparse2)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    int    n_checks = 0;
    int    n_fail = 0;
    int    stalls = 0;
    beat_t exp_q[$];
    bit    skip_out = 1'b0;
    bit    bp_random = 1'b0;
    bit    force_stall = 1'b0;

    logic [31:0] pk_data[8];
    logic [3:0]  pk_keep[8];
    int unsigned pk_len;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sole driver of dout_if.tready.
    always @(posedge aclk) begin
        #2;
        if (force_stall)    dout_if.tready = 1'b0;
        else if (bp_random) dout_if.tready = ($urandom_range(0, 3) != 0);
        else                dout_if.tready = 1'b1;
    end

    // Output monitor: a beat sampled valid&ready at negedge fires at the next posedge.
    beat_t got_b;
    beat_t exp_b;
    always @(negedge aclk) begin
        if (aresetn && dout_if.tvalid && dout_if.tready && !skip_out) begin
            got_b = {dout_if.tdata, dout_if.tkeep, dout_if.tlast};
            if (exp_q.size() == 0) begin
                check_eq("spurious_beat", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_b = exp_q.pop_front();
                check_eq("dout_beat", 64'(got_b), 64'(exp_b));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input int gap);
        int waited;
        waited = 0;
        din_if.tvalid = 1'b0;
        repeat (gap) begin
            @(posedge aclk); #1;
        end
        din_if.tdata  = d;
        din_if.tkeep  = k;
        din_if.tlast  = l;
        din_if.tvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (din_if.tready) begin
                @(posedge aclk); #1;
                break;
            end
            stalls++;
            waited++;
            if (waited > 1000) begin
                check_eq("din_ready_timeout", 64'(waited), 64'd0);
                break;
            end
            @(posedge aclk); #1;
        end
        din_if.tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || dout_if.tvalid) && n < 3000) begin
            @(posedge aclk); #1;
            n++;
        end
        check_eq("drain", {32'(exp_q.size()), 31'd0, dout_if.tvalid}, 64'd0);
    endtask

    // Reference model: collect kept bytes in order, regroup into 4-byte beats.
    task automatic model_packet();
        logic [7:0]  bytes[$];
        beat_t       b;
        int unsigned n;
        for (int unsigned i = 0; i < pk_len; i++)
            for (int unsigned lane = 0; lane < 4; lane++)
                if (pk_keep[i][lane]) bytes.push_back(pk_data[i][8*lane +: 8]);
        while (bytes.size() > 0) begin
            b = '0;
            n = (bytes.size() > 4) ? 4 : bytes.size();
            for (int unsigned j = 0; j < n; j++) begin
                b.data[8*j +: 8] = bytes.pop_front();
                b.keep[j] = 1'b1;
            end
            b.last = (bytes.size() == 0);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_packet(input bit random_gaps);
        int gap;
        for (int unsigned i = 0; i < pk_len; i++) begin
            gap = 0;
            if (random_gaps && $urandom_range(0, 3) == 0) gap = $urandom_range(1, 3);
            send_beat(pk_data[i], pk_keep[i], (i == pk_len - 1), gap);
        end
    endtask

    task automatic send_test1();
        send_beat(32'hDDCCBB00, 4'b1110, 1'b0, 0);
        send_beat(32'h44332211, 4'b1111, 1'b0, 0);
        send_beat(32'h00006655, 4'b0011, 1'b1, 0);
    endtask

    task automatic push_test1();
        exp_q.push_back({32'h11DDCCBB, 4'b1111, 1'b0});
        exp_q.push_back({32'h55443322, 4'b1111, 1'b0});
        exp_q.push_back({32'h00000066, 4'b0001, 1'b1});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words[64];
        int unsigned off;
        int unsigned nbytes;
        logic [3:0]  k;

        din_if.tvalid = 1'b0;
        din_if.tdata  = '0;
        din_if.tkeep  = '0;
        din_if.tlast  = 1'b0;
        din2_if.tvalid = 1'b0;
        din2_if.tdata  = '0;
        din2_if.tkeep  = '0;
        din2_if.tlast  = 1'b0;
        dout2_if.tready = 1'b1;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check_eq("reset_outputs", {dout_if.tvalid, dout_if.tlast, dout_if.tkeep, dout_if.tdata, err_sparse},
                 64'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check_eq("reset_din_ready", {din_if.tready, dout_if.tvalid}, 64'b10);

        // Offset-1, 9-byte packet
        push_test1();
        send_test1();
        wait_drain();

        // Aligned 64-beat packet at full rate
        for (int unsigned i = 0; i < 64; i++) begin
            words[i] = $urandom();
            exp_q.push_back({words[i], 4'b1111, (i == 63)});
        end
        stalls = 0;
        send_beat(words[0], 4'b1111, 1'b0, 0);
        check_eq("first_out_latency", dout_if.tvalid, 1'b1);
        for (int unsigned i = 1; i < 64; i++)
            send_beat(words[i], 4'b1111, (i == 63), 0);
        check_eq("full_rate_stalls", 64'(stalls), 64'd0);
        wait_drain();

        // Single partial beat
        exp_q.push_back({32'h0000BBAA, 4'b0011, 1'b1});
        send_beat(32'h00BBAA00, 4'b0110, 1'b1, 0);
        wait_drain();

        // Offset-1 packet with output held off for 10 cycles
        push_test1();
        fork
            send_test1();
            begin : stall_ctl
                int n;
                n = 0;
                while (!dout_if.tvalid && n < 100) begin
                    @(posedge aclk); #1;
                    n++;
                end
                check_eq("stall_first_out", dout_if.tvalid, 1'b1);
                force_stall = 1'b1;
                @(posedge aclk); #1;
                check_eq("stall_din_ready", din_if.tready, 1'b0);
                repeat (9) begin
                    @(posedge aclk); #1;
                end
                check_eq("stall_hold_valid", {dout_if.tvalid, dout_if.tdata}, {1'b1, 32'h11DDCCBB});
                force_stall = 1'b0;
            end
        join
        wait_drain();

        // Empty packet dropped
        send_beat(32'h12345678, 4'b0000, 1'b1, 0);
        check_eq("empty_drop", {din_if.tready, dout_if.tvalid}, 64'b10);
        repeat (3) begin
            @(posedge aclk); #1;
        end
        check_eq("empty_drop_idle", dout_if.tvalid, 1'b0);

        // Empty packet kept (DROP_EMPTY=0 instance)
        din2_if.tdata  = 32'hCAFEF00D;
        din2_if.tkeep  = 4'b0000;
        din2_if.tlast  = 1'b1;
        din2_if.tvalid = 1'b1;
        @(negedge aclk);
        check_eq("keep_empty_ready", din2_if.tready, 1'b1);
        @(posedge aclk); #1;
        din2_if.tvalid = 1'b0;
        check_eq("keep_empty_beat",
                 {din2_if.tready, dout2_if.tvalid, dout2_if.tkeep, dout2_if.tlast, dout2_if.tdata},
                 {1'b0, 1'b1, 4'b0000, 1'b1, 32'h0});
        @(posedge aclk); #1;
        check_eq("keep_empty_done", {din2_if.tready, dout2_if.tvalid}, 64'b10);
        din2_if.tdata  = 32'h00BBAA00;
        din2_if.tkeep  = 4'b0110;
        din2_if.tvalid = 1'b1;
        @(negedge aclk);
        @(posedge aclk); #1;
        din2_if.tvalid = 1'b0;
        check_eq("keep_single_beat", {dout2_if.tvalid, dout2_if.tkeep, dout2_if.tlast, dout2_if.tdata},
                 {1'b1, 4'b0011, 1'b1, 32'h0000BBAA});

        // Reset mid-packet, then a clean packet
        force_stall = 1'b1;
        @(posedge aclk); #1;
        send_beat(32'hDDCCBB00, 4'b1110, 1'b0, 0);
        send_beat(32'h44332211, 4'b1111, 1'b0, 0);
        check_eq("pre_reset_valid", dout_if.tvalid, 1'b1);
        aresetn = 1'b0;
        #1;
        check_eq("midreset_outputs",
                 {din_if.tready, dout_if.tvalid, dout_if.tlast, dout_if.tkeep, dout_if.tdata},
                 {1'b1, 38'd0});
        @(posedge aclk); #1;
        aresetn = 1'b1;
        force_stall = 1'b0;
        @(posedge aclk); #1;
        exp_q.push_back({32'h0000BBAA, 4'b0011, 1'b1});
        send_beat(32'h00BBAA00, 4'b0110, 1'b1, 0);
        wait_drain();

        // Sparse tkeep sets sticky error
        check_eq("sparse_clear", err_sparse, 1'b0);
        skip_out = 1'b1;
        send_beat(32'h44332211, 4'b0101, 1'b1, 0);
        check_eq("sparse_set", err_sparse, 1'b1);
        wait_drain();
        skip_out = 1'b0;
        exp_q.push_back({32'h0000BBAA, 4'b0011, 1'b1});
        send_beat(32'h00BBAA00, 4'b0110, 1'b1, 0);
        wait_drain();
        check_eq("sparse_sticky", err_sparse, 1'b1);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        check_eq("sparse_reset", err_sparse, 1'b0);
        @(posedge aclk); #1;

        // Randomized packets with random gaps and backpressure
        bp_random = 1'b1;
        for (int unsigned p = 0; p < 150; p++) begin
            pk_len = $urandom_range(1, 6);
            if (pk_len == 1) begin
                off = $urandom_range(0, 3);
                nbytes = $urandom_range(0, 4 - off);
                k = '0;
                for (int unsigned j = 0; j < nbytes; j++) k[off + j] = 1'b1;
                pk_keep[0] = k;
            end else begin
                off = $urandom_range(0, 3);
                pk_keep[0] = 4'b1111 << off;
                for (int unsigned i = 1; i < pk_len - 1; i++) pk_keep[i] = 4'b1111;
                nbytes = $urandom_range(1, 4);
                k = '0;
                for (int unsigned j = 0; j < nbytes; j++) k[j] = 1'b1;
                pk_keep[pk_len - 1] = k;
            end
            for (int unsigned i = 0; i < pk_len; i++) pk_data[i] = $urandom();
            model_packet();
            send_packet(1'b1);
        end
        wait_drain();
        check_eq("random_no_sparse", err_sparse, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
